demux1to8_deser: RTL
====================

Name: demux1to8_deser

Overview:
- Sequential 1-to-8 demultiplexer: steers a serial bit stream onto eight output lanes, one lane per accepted bit, and presents the completed 8-bit word on a valid/ready output.
- It is the receive-side counterpart of the 8:1 select mux. A transmitter walks the mux select 0..7; this block walks its lane index 0..7 and reassembles the word.
- It sits between a serial source and any byte-wide consumer.

Parameters:
- LSB_FIRST, 1: 1 = first accepted bit lands in lane 0; 0 = first accepted bit lands in lane 7.
- CNT_W, 16: width of the completed-word counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  serial bit valid.
- in_bit  input  1  serial data bit.
- in_ready  output  1  block can accept in_bit this cycle.
- flush  input  1  synchronous discard of the partial word; lane index returns to start.
- out_data  output  8  assembled word; lane k = out_data[k].
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data.
- lane_idx  output  3  lane the next accepted bit will fill.
- word_cnt  output  CNT_W  count of completed words, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync to clk on release):
  - out_data=0, out_valid=0, word_cnt=0, partial register=0.
  - lane_idx = 0 if LSB_FIRST, 7 otherwise.
  - in_ready = 1 once reset is released.
- Accept: a bit is accepted when in_valid & in_ready at a rising clk edge.
- Storage: 7-bit partial register holds lanes filled so far. The accepted bit is written to lane lane_idx.
- Lane stepping: lane_idx steps +1 (LSB_FIRST=1) or -1 (LSB_FIRST=0) per accepted bit, wrapping modulo 8.
- Completion bit: the bit accepted at lane 7 (LSB_FIRST=1) or lane 0 (LSB_FIRST=0) completes the word.
  - On the next edge: out_data <= partial merged with the final bit, out_valid <= 1, word_cnt increments, partial clears, lane_idx wraps to start.
  - Latency: word visible one cycle after its final bit is accepted.
- Output handshake: out_valid falls on out_valid & out_ready unless a new word completes on the same edge. In that case out_valid stays 1 and out_data takes the new word, giving back-to-back words with no bubble.
- Backpressure: in_ready = !(lane_idx is final lane && out_valid && !out_ready).
  - Only the completing bit stalls; lanes 0..6 keep filling while a word waits.
  - Sustained throughput is 1 bit/clk.
- out_data stability: out_data and out_valid are held stable while out_valid & !out_ready.
- States: IDLE (lane at start, no partial), FILL (1..7 lanes filled), STALL (final lane pending, output full).
  - IDLE->FILL on accept.
  - FILL->IDLE on completion.
  - FILL->STALL when lane is final and the output is blocked.
  - STALL->IDLE on accept after out_ready.
  - Any state->IDLE on flush.
- flush:
  - Clears partial, resets lane_idx to start, suppresses any bit accepted that cycle (in_ready forced 0 while flush=1).
  - Does not touch out_valid/out_data/word_cnt.
  - flush together with an out_ready handshake still completes that handshake.
- Reset mid-word: partial discarded, no word emitted.
- word_cnt wrap: rolls from 2^CNT_W-1 to 0 silently.
- in_bit when in_valid=0: ignored; X on in_bit must not propagate.

Decomposition:
- Shared package holds the lane-index width (3), lane count (8), and state encoding IDLE/FILL/STALL.
- One natural sub-module: demux_lane_counter (3-bit up/down wrapping index with load-to-start, direction from LSB_FIRST, terminal-lane flag).
- Partial register, output register and handshake stay in the top.

Test Plan:
- Reset then stream bits 1,0,1,1,0,0,1,0 with out_ready=1, LSB_FIRST=1 -> out_valid one cycle after the 8th bit, out_data=8'h4D, word_cnt=1, lane_idx=0.
- Same stream with LSB_FIRST=0 -> out_data=8'hB2, lane_idx sequence 7,6,...,0,7.
- out_ready=0 during two consecutive 8-bit words (0xFF, then 0x00) -> first word held at 0xFF. in_ready drops only when lane_idx=7. After one out_ready pulse the 8th bit is accepted, and out_data=0x00 appears the following cycle.
- Continuous stream of 0xA5,0x5A with out_ready=1 -> out_valid high for exactly one cycle per word with no bubbles, 16 bits in 16 accepting cycles.
- flush after 3 bits, then 8 bits of 0x3C -> out_data=0x3C (no stale bits), word_cnt increments by 1 only.
- Assert rst after 5 bits while out_valid=1 holding 0x11 -> out_valid=0, out_data=0, word_cnt=0, lane_idx=0 immediately (asynchronous); next full 8 bits produce a clean word.

Source files
------------

// File: rtl/demux1to8_deser_pkg.sv
// -----------------------------------------------------------------------------
// demux1to8_deser_pkg
// Shared definitions for the 1-to-8 serial demultiplexer / deserializer:
//   - lane index width and lane count
//   - control state encoding (IDLE / FILL / STALL)
//   - helpers returning the start lane and the final (completing) lane for a
//     given bit order
// No ports (package).
// -----------------------------------------------------------------------------
package demux1to8_deser_pkg;

  localparam int LANE_W   = 3;
  localparam int LANE_CNT = 8;

  // IDLE : lane at start, nothing buffered
  // FILL : one or more lanes of the current word filled
  // STALL: final lane pending while the previous word is still unconsumed
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  // Lane that receives the first bit of a word.
  function automatic logic [LANE_W-1:0] start_lane(input logic lsb_first);
    return lsb_first ? 3'd0 : 3'd7;
  endfunction

  // Lane whose bit completes a word.
  function automatic logic [LANE_W-1:0] final_lane(input logic lsb_first);
    return lsb_first ? 3'd7 : 3'd0;
  endfunction

endpackage

// File: rtl/demux1to8_deser_lane_counter.sv
// -----------------------------------------------------------------------------
// demux_lane_counter
// 3-bit wrapping lane index. Counts up (LSB_FIRST=1) or down (LSB_FIRST=0)
// on every accepted bit, reloads the start lane on load, and flags when the
// index sits on the final lane of a word.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset (index -> start lane)
//   load  in   synchronous reload of the start lane (has priority over step)
//   step  in   advance one lane
//   idx   out  current lane index
//   last  out  idx is the final lane of a word
// -----------------------------------------------------------------------------
module demux_lane_counter
  import demux1to8_deser_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [LANE_W-1:0] idx,
  output logic              last
);

  logic [LANE_W-1:0] idx_d;
  logic [LANE_W-1:0] idx_q;

  // Next lane: reload, step with natural 3-bit wrap, or hold.
  always_comb begin
    idx_d = idx_q;
    if (load) begin
      idx_d = start_lane(LSB_FIRST);
    end else if (step) begin
      idx_d = LSB_FIRST ? (idx_q + 3'd1) : (idx_q - 3'd1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Lane index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= start_lane(LSB_FIRST);
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == final_lane(LSB_FIRST));

endmodule

// File: rtl/demux1to8_deser.sv
// -----------------------------------------------------------------------------
// demux1to8_deser
// Sequential 1-to-8 demultiplexer: steers each accepted serial bit onto the
// next of eight lanes and presents the completed word on a valid/ready port.
// Parameters:
//   LSB_FIRST  1 = first bit of a word lands in lane 0, 0 = lands in lane 7
//   CNT_W      width of the completed-word counter (wraps silently)
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   serial bit valid
//   in_bit     in   serial data bit
//   in_ready   out  bit can be accepted this cycle
//   flush      in   synchronous discard of the partial word
//   out_data   out  assembled word, lane k = out_data[k]
//   out_valid  out  out_data holds an unconsumed word
//   out_ready  in   consumer takes out_data
//   lane_idx   out  lane the next accepted bit will fill
//   word_cnt   out  completed-word count
// -----------------------------------------------------------------------------
module demux1to8_deser
  import demux1to8_deser_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  input  logic              flush,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] lane_idx,
  output logic [CNT_W-1:0]  word_cnt
);

  logic [LANE_W-1:0] lane_s;
  logic              lane_last_s;
  logic              stall_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              complete_s;
  logic              bit_s;
  logic [LANE_W-1:0] pidx_s;
  logic [7:0]        word_s;

  logic [6:0]        partial_d;
  logic [6:0]        partial_q;
  logic [7:0]        out_data_d;
  logic [7:0]        out_data_q;
  logic              out_valid_d;
  logic              out_valid_q;
  logic [CNT_W-1:0]  word_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q;
  state_e            state_q;

  demux_lane_counter #(
    .LSB_FIRST (LSB_FIRST)
  ) u_lane_counter (
    .clk  (clk),
    .rst  (rst),
    .load (flush),
    .step (accept_s),
    .idx  (lane_s),
    .last (lane_last_s)
  );

  // Handshake decode: only the completing bit waits on a full output stage.
  always_comb begin
    // STALL always coincides with the final lane; including it keeps the
    // stall term tied to the control state as well as the raw index.
    stall_s    = out_valid_q && !out_ready && (lane_last_s || (state_q == ST_STALL));
    in_ready_s = !flush && !stall_s;
    accept_s   = in_valid && in_ready_s;
    complete_s = accept_s && lane_last_s;
    // Gate the data bit so an undriven in_bit never reaches the registers.
    bit_s      = accept_s ? in_bit : 1'b0;
  end

  // Map lanes onto the 7-bit partial store and merge the final bit.
  always_comb begin
    // The final lane is never stored, so MSB-first stores lanes 7..1 at 6..0.
    pidx_s = LSB_FIRST ? lane_s : (lane_s - 3'd1);
    word_s = LSB_FIRST ? {bit_s, partial_q} : {partial_q, bit_s};
  end

  // Partial word update: cleared on flush or completion, else one lane written.
  always_comb begin
    partial_d = partial_q;
    if (flush || complete_s) begin
      partial_d = 7'd0;
    end else if (accept_s) begin
      for (int k = 0; k < 7; k++) begin
        if (pidx_s == 3'(k)) begin
          partial_d[k] = bit_s;
        end else begin
          partial_d[k] = partial_q[k];
        end
      end
    end else begin
      partial_d = partial_q;
    end
  end

  // Output stage next state: load on completion, drop after a handshake.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    word_cnt_d  = word_cnt_q;
    if (complete_s) begin
      // A completion on the consuming edge replaces the word with no bubble.
      out_data_d  = word_s;
      out_valid_d = 1'b1;
      word_cnt_d  = word_cnt_q + CNT_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Partial and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      partial_q   <= 7'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      partial_q   <= partial_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // Control state: tracks idle / filling / stalled-on-final-lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (accept_s) begin
            state_q <= ST_FILL;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (flush || complete_s) begin
            state_q <= ST_IDLE;
          end else if (lane_last_s && out_valid_q && !out_ready) begin
            state_q <= ST_STALL;
          end else begin
            state_q <= ST_FILL;
          end
        end
        ST_STALL: begin
          if (flush || complete_s) begin
            state_q <= ST_IDLE;
          end else if (!(out_valid_q && !out_ready)) begin
            state_q <= ST_FILL;
          end else begin
            state_q <= ST_STALL;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign lane_idx  = lane_s;
  assign word_cnt  = word_cnt_q;

endmodule
